// File: rtl/serial_word_receiver.sv
// serial_word_receiver: frames a serial bit stream on a start-of-frame strobe,
// assembles DW bits (MSB- or LSB-first) into a word and presents it on a
// one-entry valid/ready buffer with a sticky overrun flag.
// Optional build macro RX_PARITY_EN adds a trailing even-parity bit per frame
// and a parity_err_o output that travels with the word.
module serial_word_receiver #(
  parameter int unsigned DW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          enb_i,
  input  logic          sof_i,
  input  logic          sin_i,
  input  logic          left_right_i,
  input  logic          out_ready_i,
  input  logic          clr_ovr_i,
  output logic [DW-1:0] out_o,
  output logic          out_valid_o,
  output logic          busy_o,
  output logic          overrun_o
`ifdef RX_PARITY_EN
  ,
  output logic          parity_err_o
`endif
);

  localparam int unsigned CntW = $clog2(DW + 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StData   = 2'd1;
`ifdef RX_PARITY_EN
  localparam logic [1:0] StParity = 2'd2;
`endif

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   sr_q, sr_d;
  logic            order_q, order_d;
  logic [DW-1:0]   out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic            overrun_q, overrun_d;
  logic [DW-1:0]   shifted;
  logic [DW-1:0]   done_word;
  logic            done;
`ifdef RX_PARITY_EN
  logic            par_q, par_d;
  logic            parity_err_q, parity_err_d;
  logic            perr;
`endif

  // One bit step in the latched order; lsb_first shifts toward bit 0.
  function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] sr, input logic b,
                                             input logic lsb_first);
    return lsb_first ? {b, sr[DW-1:1]} : {sr[DW-2:0], b};
  endfunction

  // Framing FSM: start/restart on enb&sof, collect bits, flag completion.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    order_d   = order_q;
    done      = 1'b0;
    shifted   = shift_in(sr_q, sin_i, order_q);
    done_word = shifted;
`ifdef RX_PARITY_EN
    par_d     = par_q;
    perr      = 1'b0;
    done_word = sr_q;
`endif
    if (enb_i) begin
      if (sof_i) begin
        // sof in any state starts a fresh frame; a partial frame is dropped silently.
        state_d = StData;
        cnt_d   = CntW'(1);
        order_d = left_right_i;
        sr_d    = shift_in({DW{1'b0}}, sin_i, left_right_i);
`ifdef RX_PARITY_EN
        par_d   = sin_i;
`endif
      end else begin
        case (state_q)
          StData: begin
            sr_d  = shifted;
            cnt_d = cnt_q + CntW'(1);
`ifdef RX_PARITY_EN
            par_d = par_q ^ sin_i;
`endif
            if (cnt_q == CntW'(DW - 1)) begin
`ifdef RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StIdle;
              cnt_d   = '0;
              done    = 1'b1;
`endif
            end
          end
`ifdef RX_PARITY_EN
          StParity: begin
            state_d = StIdle;
            cnt_d   = '0;
            done    = 1'b1;
            perr    = par_q ^ sin_i;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // Output buffer: load on completion if free or draining, else record overrun.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
`ifdef RX_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    if (out_valid_q && out_ready_i) out_valid_d = 1'b0;
    if (done && (!out_valid_q || out_ready_i)) begin
      out_d       = done_word;
      out_valid_d = 1'b1;
`ifdef RX_PARITY_EN
      parity_err_d = perr;
`endif
    end
    if (clr_ovr_i) overrun_d = 1'b0;
    // Set after clear so a coincident overrun wins.
    if (done && out_valid_q && !out_ready_i) overrun_d = 1'b1;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      sr_q         <= '0;
      order_q      <= 1'b0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      order_q      <= order_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
`ifdef RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign out_o       = out_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = (state_q != StIdle);
  assign overrun_o   = overrun_q;
`ifdef RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`endif

endmodule
